exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage.sv | 162 ++++++++++++++++
 tb/tb_exec_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Multi-cycle execute stage: reads two operands from an external register file, shifts B,
// runs the ALU and writes the result back. Define EXEC_IMM_EN for the immediate-operand path.
`timescale 1ns/1ps

module exec_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  rn,
   input  logic [2:0]  rm,
   input  logic [2:0]  rd,
   input  logic [1:0]  shift,
   input  logic [1:0]  aluop,
   input  logic        lds,
   input  logic [15:0] rf_data,
`ifdef EXEC_IMM_EN
   input  logic [15:0] imm,
   input  logic        bsel,
`endif
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic [15:0] data_in,
   output logic        busy,
   output logic        done,
   output logic [2:0]  status
);

   typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

   state_t      state;
   logic [2:0]  cmd_rm;
   logic [2:0]  cmd_rd;
   logic [1:0]  cmd_shift;
   logic [1:0]  cmd_aluop;
   logic        cmd_lds;
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic [15:0] c_reg;
   logic [15:0] b_shift;
   logic [15:0] alu_result;
   logic        ovf;
   logic [2:0]  flags;
   logic        skip_rdb;

`ifdef EXEC_IMM_EN
   logic        cmd_bsel;
   assign skip_rdb = cmd_bsel;
`else
   assign skip_rdb = 1'b0;
`endif

   assign data_in = c_reg;

   always_comb begin
      b_shift = b_reg;
      case (cmd_shift)
         2'b00:   b_shift = b_reg;
         2'b01:   b_shift = {b_reg[14:0], 1'b0};
         2'b10:   b_shift = {1'b0, b_reg[15:1]};
         default: b_shift = {b_reg[15], b_reg[15:1]};
      endcase

      alu_result = 16'd0;
      ovf        = 1'b0;
      case (cmd_aluop)
         2'b00: begin
            alu_result = a_reg + b_shift;
            ovf = (a_reg[15] == b_shift[15]) && (alu_result[15] != a_reg[15]);
         end
         2'b01: begin
            alu_result = a_reg - b_shift;
            ovf = (a_reg[15] != b_shift[15]) && (alu_result[15] != a_reg[15]);
         end
         2'b10:   alu_result = a_reg & b_shift;
         default: alu_result = ~b_shift;
      endcase
      flags = {ovf, alu_result[15], (alu_result == 16'd0)};
   end

   // All outputs are registered so each one is valid for the whole cycle of its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_rm    <= 3'd0;
         cmd_rd    <= 3'd0;
         cmd_shift <= 2'd0;
         cmd_aluop <= 2'd0;
         cmd_lds   <= 1'b0;
`ifdef EXEC_IMM_EN
         cmd_bsel  <= 1'b0;
`endif
         a_reg     <= 16'd0;
         b_reg     <= 16'd0;
         c_reg     <= 16'd0;
         status    <= 3'd0;
         readnum   <= 3'd0;
         writenum  <= 3'd0;
         write     <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cmd_rm    <= rm;
                  cmd_rd    <= rd;
                  cmd_shift <= shift;
                  cmd_aluop <= aluop;
                  cmd_lds   <= lds;
`ifdef EXEC_IMM_EN
                  cmd_bsel  <= bsel;
                  if (bsel) b_reg <= imm;
`endif
                  readnum   <= rn;
                  busy      <= 1'b1;
                  state     <= RDA;
               end
            end
            RDA: begin
               a_reg <= rf_data;
               if (skip_rdb) begin
                  readnum <= 3'd0;
                  state   <= EXEC;
               end else begin
                  readnum <= cmd_rm;
                  state   <= RDB;
               end
            end
            RDB: begin
               b_reg   <= rf_data;
               readnum <= 3'd0;
               state   <= EXEC;
            end
            EXEC: begin
               c_reg    <= alu_result;
               if (cmd_lds) status <= flags;
               write    <= 1'b1;
               done     <= 1'b1;
               writenum <= cmd_rd;
               state    <= WB;
            end
            WB: begin
               write    <= 1'b0;
               done     <= 1'b0;
               writenum <= 3'd0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               write    <= 1'b0;
               done     <= 1'b0;
               writenum <= 3'd0;
               readnum  <= 3'd0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: register file model, directed cases and random
// commands checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_exec_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  rn, rm, rd;
   logic [1:0]  shift, aluop;
   logic        lds;
   logic [15:0] rf_data;
   logic [2:0]  readnum, writenum;
   logic        write;
   logic [15:0] data_in;
   logic        busy, done;
   logic [2:0]  status;
`ifdef EXEC_IMM_EN
   logic [15:0] imm;
   logic        bsel;
`endif

   logic [15:0] rf [8];
   logic        pre_en;
   logic [2:0]  pre_idx;
   logic [15:0] pre_val;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [2:0]  status_model = 3'd0;

   always #5 clk = ~clk;

   exec_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rn       (rn),
      .rm       (rm),
      .rd       (rd),
      .shift    (shift),
      .aluop    (aluop),
      .lds      (lds),
      .rf_data  (rf_data),
`ifdef EXEC_IMM_EN
      .imm      (imm),
      .bsel     (bsel),
`endif
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .status   (status)
   );

   assign rf_data = rf[readnum];

   always @(posedge clk) begin
      if (write) rf[writenum] <= data_in;
      else if (pre_en) rf[pre_idx] <= pre_val;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {V,N,Z,result} from plain integer arithmetic.
   function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] sh, input logic [1:0] op);
      int au, bu, bs, r, sa, sb, sr;
      logic v;
      au = a;
      bu = b;
      case (sh)
         2'd0:    bs = bu;
         2'd1:    bs = (bu * 2) % 65536;
         2'd2:    bs = bu / 2;
         default: bs = bu / 2 + ((bu >= 32768) ? 32768 : 0);
      endcase
      sa = (au >= 32768) ? au - 65536 : au;
      sb = (bs >= 32768) ? bs - 65536 : bs;
      v  = 1'b0;
      case (op)
         2'd0: begin
            r  = (au + bs) % 65536;
            sr = sa + sb;
            v  = (sr > 32767) || (sr < -32768);
         end
         2'd1: begin
            r  = (au - bs + 65536) % 65536;
            sr = sa - sb;
            v  = (sr > 32767) || (sr < -32768);
         end
         2'd2:    r = au & bs;
         default: r = 65535 - bs;
      endcase
      return {v, (r >= 32768), (r == 0), r[15:0]};
   endfunction

   task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(negedge clk);
      pre_en  = 1'b0;
   endtask

   task automatic scramble_inputs();
      rn    = 3'($urandom);
      rm    = 3'($urandom);
      rd    = 3'($urandom);
      shift = 2'($urandom);
      aluop = 2'($urandom);
      lds   = 1'($urandom);
`ifdef EXEC_IMM_EN
      imm   = 16'($urandom);
      bsel  = 1'($urandom);
`endif
   endtask

   task automatic run_cmd(input string tag, input logic [2:0] rn_i, input logic [2:0] rm_i,
                          input logic [2:0] rd_i, input logic [1:0] sh_i, input logic [1:0] op_i,
                          input logic lds_i, input logic bsel_i, input logic [15:0] imm_i,
                          input logic hold_i);
      logic [15:0] a, b;
      logic [18:0] m;
      int exp_done, done_at, idle_at, done_cnt, wr_cnt;
      a = rf[rn_i];
      b = bsel_i ? imm_i : rf[rm_i];
      m = model(a, b, sh_i, op_i);
      exp_done = bsel_i ? 3 : 4;
      done_at = 0; idle_at = 0; done_cnt = 0; wr_cnt = 0;

      @(negedge clk);
      rn = rn_i; rm = rm_i; rd = rd_i; shift = sh_i; aluop = op_i; lds = lds_i;
`ifdef EXEC_IMM_EN
      imm = imm_i; bsel = bsel_i;
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold_i) start = 1'b0;
      scramble_inputs();

      for (int s = 1; s <= 8; s++) begin
         @(negedge clk);
         if (s == 1) chk({tag, "_readnum_rn"}, readnum, rn_i);
         if (s == 2 && !bsel_i) chk({tag, "_readnum_rm"}, readnum, rm_i);
         if (s >= exp_done - 1 && s <= exp_done) chk({tag, "_readnum_zero"}, readnum, 3'd0);
         if (bsel_i && s <= exp_done) chk({tag, "_readnum_not_rm"}, (readnum != rm_i), 1);
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = s;
            if (hold_i) start = 1'b0;
         end
         if (write) begin
            wr_cnt++;
            chk({tag, "_writenum"}, writenum, rd_i);
         end
         if (!busy && idle_at == 0) idle_at = s;
      end
      start = 1'b0;

      if (lds_i) status_model = m[18:16];
      chk({tag, "_done_at"},  done_at,  exp_done);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_wr_cnt"},   wr_cnt,   1);
      chk({tag, "_idle_at"},  idle_at,  exp_done + 1);
      chk({tag, "_status"},   status,   status_model);
      chk({tag, "_rf_rd"},    rf[rd_i], m[15:0]);
      chk({tag, "_data_in"},  data_in,  m[15:0]);
      $display("cmd %s rn=%0d rm=%0d rd=%0d sh=%0d op=%0d lds=%0d -> R%0d=%h status=%b",
               tag, rn_i, rm_i, rd_i, sh_i, op_i, lds_i, rd_i, rf[rd_i], status);
   endtask

   initial begin
      logic [15:0] old_val;
      rst_n = 1'b0; start = 1'b0; pre_en = 1'b0; pre_idx = 3'd0; pre_val = 16'd0;
      rn = 3'd0; rm = 3'd0; rd = 3'd0; shift = 2'd0; aluop = 2'd0; lds = 1'b0;
`ifdef EXEC_IMM_EN
      imm = 16'd0; bsel = 1'b0;
`endif
      #2;
      chk("reset_busy",     busy,     1'b0);
      chk("reset_done",     done,     1'b0);
      chk("reset_write",    write,    1'b0);
      chk("reset_status",   status,   3'd0);
      chk("reset_readnum",  readnum,  3'd0);
      chk("reset_writenum", writenum, 3'd0);
      chk("reset_data_in",  data_in,  16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) set_reg(3'(i), 16'd0);

      set_reg(3'd1, 16'd7);
      set_reg(3'd2, 16'd5);
      run_cmd("add", 3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0, 1'b0);
      chk("add_r3", rf[3], 16'd12);
      chk("add_status", status, 3'b000);

      set_reg(3'd0, 16'd8);
      set_reg(3'd1, 16'd4);
      run_cmd("sub_shl", 3'd0, 3'd1, 3'd0, 2'b01, 2'b01, 1'b1, 1'b0, 16'd0, 1'b0);
      chk("sub_r0", rf[0], 16'd0);
      chk("sub_status", status, 3'b001);

      set_reg(3'd4, 16'h7FFF);
      set_reg(3'd5, 16'd1);
      run_cmd("ovf", 3'd4, 3'd5, 3'd6, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0, 1'b0);
      chk("ovf_r6", rf[6], 16'h8000);
      chk("ovf_status", status, 3'b110);
      run_cmd("ovf_nolds", 3'd4, 3'd5, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("ovf_nolds_status", status, 3'b110);

      set_reg(3'd6, 16'd0);
      set_reg(3'd7, 16'h8001);
      run_cmd("lsr", 3'd6, 3'd7, 3'd3, 2'b10, 2'b00, 1'b1, 1'b0, 16'd0, 1'b0);
      chk("lsr_r3", rf[3], 16'h4000);
      run_cmd("asr", 3'd6, 3'd7, 3'd3, 2'b11, 2'b00, 1'b1, 1'b0, 16'd0, 1'b0);
      chk("asr_r3", rf[3], 16'hC000);
      run_cmd("not", 3'd6, 3'd7, 3'd3, 2'b00, 2'b11, 1'b1, 1'b0, 16'd0, 1'b0);
      chk("not_r3", rf[3], 16'h7FFE);

      run_cmd("hold_start", 3'd1, 3'd2, 3'd5, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0, 1'b1);

      // Abort a command during write-back.
      set_reg(3'd4, 16'h1234);
      old_val = rf[4];
      @(negedge clk);
      rn = 3'd1; rm = 3'd2; rd = 3'd4; shift = 2'b00; aluop = 2'b00; lds = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int s = 2; s <= 4; s++) @(negedge clk);
      chk("abort_write_before", write, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_write",    write,    1'b0);
      chk("abort_done",     done,     1'b0);
      chk("abort_busy",     busy,     1'b0);
      chk("abort_status",   status,   3'd0);
      chk("abort_writenum", writenum, 3'd0);
      chk("abort_data_in",  data_in,  16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      status_model = 3'd0;
      @(negedge clk);
      chk("abort_rf_unchanged", rf[4], old_val);
      $display("cmd abort_wb rd=4 R4=%h status=%b", rf[4], status);

`ifdef EXEC_IMM_EN
      set_reg(3'd2, 16'd10);
      run_cmd("imm", 3'd2, 3'd5, 3'd4, 2'b00, 2'b00, 1'b1, 1'b1, 16'h0003, 1'b0);
      chk("imm_r4", rf[4], 16'd13);
`endif

      for (int i = 0; i < 20; i++) begin
         logic [15:0] v;
         case ($urandom_range(0, 3))
            0:       v = 16'h7FFF;
            1:       v = 16'h8000;
            default: v = 16'($urandom);
         endcase
         set_reg(3'($urandom), v);
         set_reg(3'($urandom), 16'($urandom));
         run_cmd($sformatf("rnd%0d", i), 3'($urandom), 3'($urandom), 3'($urandom),
                 2'($urandom), 2'($urandom), 1'($urandom), 1'b0, 16'd0, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
